// File: rtl/prog_clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   MIN_DIV    smallest divisor a channel will ever run with
//   chWidth    width of the channel-select field for a given channel count
//   coerceDiv  maps requested divisors 0 and 1 onto MIN_DIV
package prog_clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned chWidth(input int unsigned numCh);
    return (numCh < 2) ? 1 : $clog2(numCh);
  endfunction

  function automatic logic [31:0] coerceDiv(input logic [31:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active divisor, shadow divisor and the
// registered outClk/tick outputs.
//   inClk     system clock
//   reset     synchronous, active-high
//   en        run enable; low clears the count and outputs
//   load      store load_div into the shadow and mark it pending
//   load_div  already-coerced divisor (>= 2)
//   pending   a shadow divisor is waiting for the period boundary
//   outClk    divided clock, high for ceil(div/2) cycles per period
//   tick      one-cycle strobe on the last cycle of each period
module clk_div_channel #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             inClk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             pending,
  output logic             outClk,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W:0]   hi;
  logic             wrap;

  // One extra bit so div = 2^DIV_W-1 does not overflow when rounding up.
  assign hi   = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
  assign wrap = (cnt == div - DIV_W'(1));

  always_ff @(posedge inClk) begin
    if (reset) begin
      cnt     <= '0;
      div     <= DIV_W'(DEFAULT_DIV);
      shadow  <= DIV_W'(DEFAULT_DIV);
      pending <= 1'b0;
      outClk  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (en) begin
        cnt    <= wrap ? '0 : cnt + DIV_W'(1);
        outClk <= ({1'b0, cnt} < hi);
        tick   <= wrap;
        if (wrap && pending) begin
          div     <= shadow;
          pending <= 1'b0;
        end
      end else begin
        cnt    <= '0;
        outClk <= 1'b0;
        tick   <= 1'b0;
        if (pending) begin
          div     <= shadow;
          pending <= 1'b0;
        end
      end
      // The top only strobes load while pending is clear, so a load on the
      // wrap edge arms the next boundary instead of being consumed now.
      if (load) begin
        shadow  <= load_div;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider with a valid/ready config port.
//   inClk      system clock
//   reset      synchronous, active-high
//   cfg_valid  config write request
//   cfg_ch     target channel (out-of-range writes are accepted and dropped)
//   cfg_div    requested divisor (0 and 1 become 2)
//   cfg_ready  write can be accepted (combinational)
//   ch_en      per-channel run enable
//   outClk     divided clocks, registered
//   tick       per-period strobes, registered
module prog_clk_divider
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CH_W       = chWidth(NUM_CH)
) (
  input  logic              inClk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] outClk,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pendingVec;
  logic [NUM_CH-1:0] loadVec;
  logic [DIV_W-1:0]  coercedDiv;

  assign coercedDiv = DIV_W'(coerceDiv(32'(cfg_div)));

  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(cfg_ch) == i) cfg_ready = ~pendingVec[i];
    end
  end

  always_comb begin
    loadVec = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(cfg_ch) == i) loadVec[i] = cfg_valid & cfg_ready;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) uCh (
      .inClk    (inClk),
      .reset    (reset),
      .en       (ch_en[g]),
      .load     (loadVec[g]),
      .load_div (coercedDiv),
      .pending  (pendingVec[g]),
      .outClk   (outClk[g]),
      .tick     (tick[g])
    );
  end

endmodule
